// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a byte stream into big-endian 512-bit SHA-256 blocks
// and appends the 0x80 marker, zero fill and 64-bit message bit-length.
// Latency: last byte -> block valid in 2 cycles (1 cycle for the 64th byte);
// extra pad/length blocks appear 2 cycles after the previous handshake.
// Backpressure: in_ready is high only while filling. A block is held with
// stable data/flags until blk_ready. Input bytes stall meanwhile.
//
// Ports:
//   clock, resetn                 : clock, synchronous active-low reset
//   in_data/in_valid/in_last      : message byte stream, in_last marks final byte
//   in_ready                      : byte accepted this cycle when in_valid
//   blk_data/blk_valid/blk_ready  : padded block, byte 0 at [511:504]
//   blk_first/blk_last            : first block of message / final block of message
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
);

  // The byte counter is kept in bytes; the emitted field is bits (count << 3).
  localparam int CNT_W = LEN_W - 3;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PAD    = 2'd1,
    LENBLK = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [511:0]       blk_q, blk_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               final_q, final_d;
  logic               padp_q, padp_d;
  logic               lenp_q, lenp_d;
  logic [63:0]        len_field;

  // Bit length, zero-extended to the 64-bit SHA-256 length field.
  always_comb begin
    len_field = '0;
    len_field[LEN_W-1:0] = {cnt_q, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    final_d = final_q;
    padp_d  = padp_q;
    lenp_d  = lenp_q;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int i = 0; i < 64; i++) begin
            if (6'(i) == idx_q) blk_d[511-8*i -: 8] = in_data;
          end
          idx_d = idx_q + 6'd1;
          cnt_d = cnt_q + CNT_W'(1);
          if (idx_q == 6'd63) begin
            // Full block: ship it first; a final byte here still owes a
            // whole padding block afterwards.
            state_d = EMIT;
            final_d = 1'b0;
            padp_d  = in_last;
          end else if (in_last) begin
            state_d = PAD;
          end
        end
      end

      PAD: begin
        for (int i = 0; i < 64; i++) begin
          if (6'(i) == idx_q) begin
            blk_d[511-8*i -: 8] = 8'h80;
          end else if (6'(i) > idx_q) begin
            if (idx_q <= 6'd55 && i >= 56) blk_d[511-8*i -: 8] = len_field[8*(63-i) +: 8];
            else                           blk_d[511-8*i -: 8] = 8'h00;
          end
        end
        if (idx_q <= 6'd55) begin
          final_d = 1'b1;
        end else begin
          // Marker landed in the length area; length goes in its own block.
          final_d = 1'b0;
          lenp_d  = 1'b1;
        end
        state_d = EMIT;
      end

      LENBLK: begin
        blk_d   = {448'b0, len_field};
        final_d = 1'b1;
        state_d = EMIT;
      end

      EMIT: begin
        if (blk_ready) begin
          first_d = 1'b0;
          idx_d   = 6'd0;
          if (final_q) begin
            state_d = FILL;
            cnt_d   = '0;
            first_d = 1'b1;
          end else if (padp_q) begin
            state_d = PAD;
            padp_d  = 1'b0;
          end else if (lenp_q) begin
            state_d = LENBLK;
            lenp_d  = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= FILL;
      blk_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      final_q <= 1'b0;
      padp_q  <= 1'b0;
      lenp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      final_q <= final_d;
      padp_q  <= padp_d;
      lenp_q  <= lenp_d;
    end
  end

  assign in_ready  = (state_q == FILL) && resetn;
  assign blk_valid = (state_q == EMIT);
  // Flags are only meaningful alongside blk_valid; keep them low otherwise.
  assign blk_first = (state_q == EMIT) && first_q;
  assign blk_last  = (state_q == EMIT) && final_q;
  assign blk_data  = blk_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: messages are padded by a queue-based model
// (append 0x80, zero-fill to 56 mod 64, append bit length) and the resulting
// blocks/flags are compared with the blocks captured at each handshake.
module tb_sha256_msg_padder;

  logic         clock = 1'b0;
  logic         resetn;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;

  always #5 clock = ~clock;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rdy_ctl = 1;   // 0: hold low, 1: always high, 2: random
  int gaps    = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] cap_dat[$];
  logic         cap_first[$];
  logic         cap_last[$];
  logic [511:0] exp_dat[$];
  logic         exp_first[$];
  logic         exp_last[$];
  int           rise_acc[$];
  int           rise_hs[$];
  int           acc_cyc = 0;
  int           hs_cyc  = 0;
  logic         bv_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    case (rdy_ctl)
      0:       blk_ready = 1'b0;
      1:       blk_ready = 1'b1;
      default: blk_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observe at the falling edge: inputs were set just after the rising edge,
  // so these values are what the next rising edge will act on.
  always @(negedge clock) begin
    if (resetn && in_valid && in_ready) acc_cyc = cyc;
    if (resetn && blk_valid && !bv_prev) begin
      rise_acc.push_back(cyc - acc_cyc);
      rise_hs.push_back(cyc - hs_cyc);
    end
    if (resetn && blk_valid && blk_ready) begin
      cap_dat.push_back(blk_data);
      cap_first.push_back(blk_first);
      cap_last.push_back(blk_last);
      hs_cyc = cyc;
    end
    bv_prev = resetn && blk_valid;
  end

  // Reference padding of msg_q, appended to the expected block list.
  task automatic model_add();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] b;
    int           nb;
    p = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    for (int bi = 0; bi < nb; bi++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*bi + j];
      exp_dat.push_back(b);
      exp_first.push_back(bi == 0);
      exp_last.push_back(bi == nb - 1);
    end
  endtask

  task automatic make_msg(input int n, input int rnd, input logic [7:0] val);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(rnd != 0 ? 8'($urandom) : val);
  endtask

  task automatic clear_obs();
    rise_acc.delete();
    rise_hs.delete();
  endtask

  // Drives msg_q[lo..hi-1]; in_last rides on the message's final byte.
  task automatic drive_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int k;
      if (gaps != 0) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));
          in_data  = 8'($urandom);
          @(posedge clock); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      k = 0;
      forever begin
        @(negedge clock);
        if (in_ready) break;
        k++;
        if (k > 3000) break;
      end
      if (k > 3000) begin
        vectors++; errors++;
        $display("FAIL drive byte %0d: in_ready stayed 0, required 1", i);
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clock); #1;
        return;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    int k = 0;
    while (cap_dat.size() < n && k < 5000) begin
      @(posedge clock); #1;
      k++;
    end
    repeat (6) begin @(posedge clock); #1; end
  endtask

  task automatic check_all(input string name);
    int n;
    wait_blocks(exp_dat.size());
    vectors++;
    if (cap_dat.size() !== exp_dat.size()) begin
      errors++;
      $display("FAIL %s block count: got %0d required %0d", name, cap_dat.size(), exp_dat.size());
    end
    n = (cap_dat.size() < exp_dat.size()) ? cap_dat.size() : exp_dat.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (cap_dat[i] !== exp_dat[i] || cap_first[i] !== exp_first[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL %s blk%0d: got %h f%0b l%0b required %h f%0b l%0b", name, i,
                 cap_dat[i], cap_first[i], cap_last[i], exp_dat[i], exp_first[i], exp_last[i]);
      end
    end
    cap_dat.delete(); cap_first.delete(); cap_last.delete();
    exp_dat.delete(); exp_first.delete(); exp_last.delete();
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_first !== 1'b0 || blk_last !== 1'b0 || blk_data !== 512'b0) begin
      errors++;
      $display("FAIL reset state: rdy=%b vld=%b f=%b l=%b data_nz=%b, required 0 0 0 0 0",
               in_ready, blk_valid, blk_first, blk_last, |blk_data);
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready after reset: got %b required 1", in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_hello();
    string s = "hello world";
    logic [511:0] b;
    rdy_ctl = 1; gaps = 0;
    clear_obs();
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    model_add();
    drive_range(0, msg_q.size());
    wait_blocks(1);
    b = (cap_dat.size() > 0) ? cap_dat[0] : 512'bx;
    vectors++;
    if (b[511:416] !== 96'h68656c6c6f20776f726c6480 || b[415:64] !== 352'b0 || b[63:0] !== 64'h58) begin
      errors++;
      $display("FAIL hello block: got %h required 68656c6c6f20776f726c6480..0058", b);
    end
    vectors++;
    if (rise_acc.size() < 1 || rise_acc[0] !== 2) begin
      errors++;
      $display("FAIL hello latency: got %0d required 2", rise_acc.size() > 0 ? rise_acc[0] : -1);
    end
    check_all("hello");
  endtask

  task automatic test_55();
    logic [511:0] b;
    clear_obs();
    make_msg(55, 0, 8'h61);
    model_add();
    drive_range(0, 55);
    wait_blocks(1);
    b = (cap_dat.size() > 0) ? cap_dat[0] : 512'bx;
    vectors++;
    if (b[511-8*55 -: 8] !== 8'h80 || b[63:0] !== 64'h1B8 || b[511:512-8*55] !== {55{8'h61}}) begin
      errors++;
      $display("FAIL len55 block: got %h required 55x61,80,len 1b8", b);
    end
    vectors++;
    if (rise_acc.size() < 1 || rise_acc[0] !== 2) begin
      errors++;
      $display("FAIL len55 latency: got %0d required 2", rise_acc.size() > 0 ? rise_acc[0] : -1);
    end
    check_all("len55");
  endtask

  task automatic test_56();
    logic [511:0] b;
    clear_obs();
    make_msg(56, 0, 8'h61);
    model_add();
    drive_range(0, 56);
    wait_blocks(2);
    b = (cap_dat.size() > 1) ? cap_dat[1] : 512'bx;
    vectors++;
    if (b !== {448'b0, 64'h1C0}) begin
      errors++;
      $display("FAIL len56 length block: got %h required zeros,1c0", b);
    end
    vectors++;
    if (rise_hs.size() < 2 || rise_hs[1] !== 2) begin
      errors++;
      $display("FAIL len56 length-block latency: got %0d required 2", rise_hs.size() > 1 ? rise_hs[1] : -1);
    end
    check_all("len56");
  endtask

  task automatic test_64();
    logic [511:0] b;
    clear_obs();
    make_msg(64, 0, 8'h61);
    model_add();
    drive_range(0, 64);
    wait_blocks(2);
    b = (cap_dat.size() > 1) ? cap_dat[1] : 512'bx;
    vectors++;
    if (b !== {8'h80, 440'b0, 64'h200}) begin
      errors++;
      $display("FAIL len64 pad block: got %h required 80,zeros,200", b);
    end
    vectors++;
    if (rise_acc.size() < 2 || rise_acc[0] !== 1 || rise_hs[1] !== 2) begin
      errors++;
      $display("FAIL len64 latency: got %0d/%0d required 1/2",
               rise_acc.size() > 0 ? rise_acc[0] : -1, rise_hs.size() > 1 ? rise_hs[1] : -1);
    end
    check_all("len64");
  endtask

  task automatic test_backpressure();
    logic [511:0] sd;
    logic         sf, sl;
    int           k;
    clear_obs();
    make_msg(100, 1, 8'h00);
    model_add();
    rdy_ctl = 0;
    drive_range(0, 64);
    k = 0;
    while (!blk_valid && k < 100) begin @(negedge clock); k++; end
    @(negedge clock);
    sd = blk_data; sf = blk_first; sl = blk_last;
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = msg_q[64]; in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      vectors++;
      if (in_ready !== 1'b0 || blk_valid !== 1'b1 || blk_data !== sd || blk_first !== sf || blk_last !== sl) begin
        errors++;
        $display("FAIL backpressure hold c%0d: rdy=%b vld=%b stable=%b, required 0 1 1",
                 c, in_ready, blk_valid, (blk_data === sd) && (blk_first === sf) && (blk_last === sl));
      end
    end
    rdy_ctl = 1;
    @(posedge clock); #1;
    drive_range(64, 100);
    check_all("backpressure");
  endtask

  task automatic test_reset_mid();
    // Partial message discarded.
    clear_obs();
    rdy_ctl = 1; gaps = 0;
    make_msg(40, 1, 8'h00);
    drive_range(0, 20);
    pulse_reset();
    @(negedge clock);
    vectors++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset mid-message: vld=%b rdy=%b required 0 1", blk_valid, in_ready);
    end
    @(posedge clock); #1;
    // Held block discarded by reset.
    rdy_ctl = 0;
    make_msg(70, 1, 8'h00);
    drive_range(0, 64);
    repeat (3) begin @(posedge clock); #1; end
    pulse_reset();
    @(negedge clock);
    vectors++;
    if (blk_valid !== 1'b0 || cap_dat.size() !== 0) begin
      errors++;
      $display("FAIL reset mid-emit: vld=%b captured=%0d required 0 0", blk_valid, cap_dat.size());
    end
    rdy_ctl = 1;
    @(posedge clock); #1;
    // Two back-to-back "abc" messages, each a fresh first block.
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    model_add();
    drive_range(0, 3);
    model_add();
    drive_range(0, 3);
    wait_blocks(2);
    vectors++;
    if (cap_dat.size() < 2 || cap_dat[0] !== {32'h61626380, 416'b0, 64'h18} ||
        cap_first[0] !== 1'b1 || cap_first[1] !== 1'b1 || cap_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL abc after reset: got %h f%0b required 61626380..0018 f1",
               cap_dat.size() > 0 ? cap_dat[0] : 512'bx, cap_dat.size() > 0 ? cap_first[0] : 1'bx);
    end
    check_all("abc_b2b");
  endtask

  task automatic test_random();
    rdy_ctl = 2; gaps = 1;
    for (int m = 0; m < 8; m++) begin
      make_msg($urandom_range(1, 200), 1, 8'h00);
      model_add();
      drive_range(0, msg_q.size());
    end
    check_all("random");
    rdy_ctl = 1; gaps = 0;
  endtask

  initial begin
    blk_ready = 1'b1;
    test_reset();
    test_hello();
    test_55();
    test_56();
    test_64();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Byte-stream front end for the SHA256 core. Packs an arbitrary-length message, one byte per cycle, into big-endian 512-bit blocks and applies SHA-256 padding: 0x80 marker, zero fill, and a 64-bit bit-length. Each block is presented on a valid/ready port. First/last flags tell the chaining logic when to load the IV and when the core's output is the final digest.

Parameters:
LEN_W, 64, width of internal bit-length counter (LEN_W must be <= 64 and >= 6); upper bits of the emitted 64-bit length field are zero-extended.

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
in_data  input  8  message byte
in_valid  input  1  in_data valid
in_last  input  1  qualifies final byte of message (valid only with in_valid)
in_ready  output  1  padder accepts byte this cycle
blk_data  output  512  padded block, byte 0 at [511:504]
blk_valid  output  1  blk_data/flags valid
blk_ready  input  1  downstream accepts block
blk_first  output  1  block is first of its message (core uses IV)
blk_last  output  1  block is final of message (core output is digest)

Behaviour:
- States: FILL, PAD, LENBLK, EMIT. Reset state is FILL with idx=0, byte count=0, first_pending=1.
- Reset (resetn=0 at clock edge): blk_valid=0, blk_first=0, blk_last=0, blk_data=0, buffer cleared. in_ready is forced 0 while resetn=0.
- in_ready = (state==FILL) && resetn. It is combinational from state only, never from in_valid.
- FILL: a byte is accepted when in_valid && in_ready. It is written to buffer byte idx, then idx++ and count++ (count wraps modulo 2^(LEN_W-3)).
  - Accept at idx=63, in_last=0: go to EMIT, final=0.
  - Accept at idx=63, in_last=1: go to EMIT, final=0, pad_pending=1.
  - Accept at idx<63, in_last=1: go to PAD.
- PAD (one cycle): buffer[idx]=0x80; all bytes above idx are zeroed.
  - If idx<=55: bytes 56..63 = {count,3'b000} big-endian, final=1.
  - Otherwise: final=0, len_pending=1.
  - Then go to EMIT.
- LENBLK (one cycle): bytes 0..55 are zero, bytes 56..63 hold the length, final=1. Then go to EMIT.
- EMIT: blk_valid=1. blk_data, blk_first and blk_last are held stable until blk_ready is sampled high. blk_first=first_pending, blk_last=final. On handshake, blk_valid drops the next cycle, first_pending is cleared and idx resets to 0. Next state:
  - final=1: go to FILL, clear count, first_pending=1.
  - pad_pending: go to PAD with idx=0, clear pad_pending.
  - len_pending: go to LENBLK, clear len_pending.
  - Otherwise: go to FILL.
- Latency:
  - Last byte accepted at cycle T with idx<=55 → blk_valid at T+2.
  - Byte 64 accepted at T → blk_valid at T+1.
  - Extra pad or length block → blk_valid 2 cycles after the prior handshake.
- Back-to-back messages: the next message's first byte is accepted from the first FILL cycle after the final handshake.
- Zero-length messages are not supported; every message carries at least one byte.
- in_last without in_valid is ignored.
- Reset mid-message or mid-EMIT discards the partial block and all counters. The next cycle shows blk_valid=0, and the next block carries blk_first=1.
- Max message length: 2^(LEN_W-3)-1 bytes. Beyond that the length field wraps silently.

Test Plan:
- "hello world" (11 bytes 68 65 6c 6c 6f 20 77 6f 72 6c 64, last on 64), blk_ready=1 → one block 68656c6c6f20776f726c6480 followed by zeros, ending in 0000000000000058. blk_first=blk_last=1, blk_valid at T+2. Fed through SHA256 with the standard IV → digest b94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9.
- 55 bytes of 0x61 → single block: byte 55=0x80, length field 0x1B8, first=last=1.
- 56 bytes of 0x61 → two blocks.
  - Block 1: byte 56=0x80, bytes 57..63=0, first=1, last=0.
  - Block 2: all zero except length 0x1C0, first=0, last=1.
- 64 bytes of 0x61 → block 1 is all 0x61 (first=1, last=0). Block 2 is 0x80, zeros, length 0x200, last=1.
- Backpressure: hold blk_ready=0 for 10 cycles during EMIT → blk_data and flags stable, in_ready=0, input bytes offered are not consumed. Release → single handshake, no duplicate block.
- Reset mid-message: feed 20 bytes, pulse resetn=0 for 1 cycle, then send "abc" → single block 61626380 followed by zeros with length 0x18, first=last=1. Back-to-back second message "abc" → blk_first=1 again.
